// File: rtl/apb_mbox_regfile_slave_if.sv
// APB3 bus bundle between the bridge (master) and the mailbox/register slave.
interface apb_mbox_regfile_slave_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [31:0]               pwdata;
    logic [31:0]               prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mbox_regfile_slave.sv
// APB3 slave: control registers, live status word and a hardware-filled mailbox FIFO.
// Optional IRQ_EN register and mailbox interrupt are built when MBOX_IRQ_EN is defined.
//
// state    | meaning
// S_IDLE   | no transfer; setup phase loads the wait counter
// S_WAIT   | access phase, counter running down, pready=0
// S_ACCESS | pready=1 for one cycle, commit on this edge
module apb_mbox_regfile_slave #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_REGS       = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int WAIT_CYCLES    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    apb_mbox_regfile_slave_if.slave apb,
    output logic [NUM_REGS*32-1:0]  regs_o,
    input  logic [31:0]             status_i,
    input  logic                    mbox_push_i,
    input  logic [31:0]             mbox_data_i,
    output logic                    mbox_full_o,
    output logic                    irq_o
);
    localparam int WW = APB_ADDR_WIDTH - 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [WW-1:0] W_STATUS = WW'(64);
    localparam logic [WW-1:0] W_MDATA  = WW'(65);
    localparam logic [WW-1:0] W_MSTAT  = WW'(66);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_e;

    state_e                     state_q;
    logic [3:0]                 cnt_q;
    logic [NUM_REGS-1:0][31:0]  regs_q, regs_d;
    logic [31:0]                mem_q [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       ovf_q, ovf_d;

    logic [WW-1:0]              word;
    logic                       wr, access_ph, pready, commit;
    logic                       hit_ctrl, hit_status, hit_mdata, hit_mstat;
    logic                       empty, full, pop, push;
    logic [31:0]                rd_val;
    logic                       err;

`ifdef MBOX_IRQ_EN
    localparam logic [WW-1:0] W_IRQEN = WW'(67);
    logic hit_irqen;
    logic irq_en_q, irq_en_d, irq_q, irq_d;
    assign hit_irqen = (word == W_IRQEN);
`endif

    assign word       = apb.paddr[APB_ADDR_WIDTH-1:2];
    assign wr         = apb.pwrite;
    assign access_ph  = apb.psel & apb.penable;
    assign hit_ctrl   = (word < WW'(NUM_REGS));
    assign hit_status = (word == W_STATUS);
    assign hit_mdata  = (word == W_MDATA);
    assign hit_mstat  = (word == W_MSTAT);

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!apb.psel) begin
                        state_q <= S_IDLE;
                    end else if (access_ph) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q <= 4'd1) state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign pready = (state_q == S_ACCESS);
    assign commit = access_ph & pready;

    always_comb begin
        rd_val = '0;
        err    = 1'b0;
        if (hit_ctrl) begin
            for (int k = 0; k < NUM_REGS; k++)
                if (word == WW'(k)) rd_val = regs_q[k];
        end else if (hit_status) begin
            if (wr) err = 1'b1;
            else    rd_val = status_i;
        end else if (hit_mdata) begin
            if (wr || empty) err = 1'b1;
            else             rd_val = mem_q[rd_ptr_q];
        end else if (hit_mstat) begin
            rd_val = {24'b0, ovf_q, full, empty, 5'(count_q)};
`ifdef MBOX_IRQ_EN
        end else if (hit_irqen) begin
            rd_val = {31'b0, irq_en_q};
`endif
        end else begin
            err = 1'b1;
        end
    end

    assign apb.pready  = pready;
    assign apb.pslverr = pready & err;
    assign apb.prdata  = (pready && !err && !wr) ? rd_val : '0;

    // A full FIFO still accepts a push when an APB pop commits on the same edge.
    assign pop  = commit & ~wr & hit_mdata & ~empty;
    assign push = mbox_push_i & (~full | pop);

    always_comb begin
        regs_d   = regs_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (commit && wr) begin
            for (int k = 0; k < NUM_REGS; k++)
                if (word == WW'(k)) regs_d[k] = apb.pwdata;
        end
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        if (mbox_push_i && full && !pop)
            ovf_d = 1'b1;
        else if (commit && wr && hit_mstat && apb.pwdata[7])
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= mbox_data_i;
    end

    assign regs_o      = regs_q;
    assign mbox_full_o = full;

`ifdef MBOX_IRQ_EN
    always_comb begin
        irq_en_d = irq_en_q;
        if (commit && wr && hit_irqen) irq_en_d = apb.pwdata[0];
        irq_d = irq_en_q & (~empty | ovf_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif
endmodule

// File: doc/apb_mbox_regfile_slave.md
Name: apb_mbox_regfile_slave

Overview:
- APB3 responder for one peripheral slot of the APB bridge's `psel` vector; it is the slave end of the bridge's master interface.
- Provides NUM_REGS read/write control registers, a read-only status word, and an inbound mailbox FIFO filled by hardware and drained by APB reads.
- Wait states are programmable by parameter. Out-of-map and illegal accesses are flagged with `pslverr`.

Parameters:
- APB_ADDR_WIDTH, 12, width of `paddr`; `paddr[1:0]` is ignored.
- NUM_REGS, 8, number of 32-bit RW control registers (1..32).
- FIFO_DEPTH, 4, mailbox entries; must be a power of 2, 2..16.
- WAIT_CYCLES, 1, wait states inserted in the access phase (0..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write.
- paddr  in  APB_ADDR_WIDTH  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data; valid when `pready`=1.
- pready  out  1  transfer complete.
- pslverr  out  1  error; valid when `pready`=1.
- regs_o  out  NUM_REGS*32  control register contents; reg k is at bits [32k+31:32k].
- status_i  in  32  sampled live on STATUS read.
- mbox_push_i  in  1  hardware push strobe.
- mbox_data_i  in  32  push data.
- mbox_full_o  out  1  FIFO full.
- irq_o  out  1  mailbox interrupt.

Behaviour:
- Reset: one clock, `clk_i`; `rst_i` is a synchronous, active-high reset.
  - On reset, clear `prdata`, `pready`, `pslverr`, `regs_o`, FIFO pointers/count, the overflow bit, IRQ_EN and `irq_o` to 0. `mbox_full_o` also resets to 0.
  - The FSM returns to IDLE; any in-flight transfer is dropped with no side effects.
- Address map (word offset = `paddr[APB_ADDR_WIDTH-1:2]`):
  - 0x000 + 4k, k<NUM_REGS: CTRL[k], RW.
  - 0x100: STATUS, RO; returns `status_i`.
  - 0x104: MBOX_DATA, RO. A read pops the head entry. A write is an error.
  - 0x108: MBOX_STAT, RW1C.
    - Bits [4:0] = count, [5] = empty, [6] = full, [7] = overflow sticky; other bits read 0.
    - Writing 1 to bit 7 clears overflow; other written bits are ignored.
  - 0x10C: IRQ_EN, bit 0 RW (optional feature only).
  - Any other address: error.
  - A write to a RO location is an error and has no effect.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE → WAIT when `psel`=1 and `penable`=0 (setup phase). This loads the wait counter with WAIT_CYCLES.
  - WAIT: `pready`=0 while the counter is nonzero; the counter decrements each cycle that `psel`&`penable`=1.
  - When the counter is 0 in the access phase, go to ACCESS.
  - ACCESS: `pready`=1 for exactly one cycle, then return to IDLE.
  - `pready` is driven combinationally from the state and counter.
  - With WAIT_CYCLES=0, `pready`=1 in the first access cycle; total transfer is 2 cycles. WAIT_CYCLES=N gives N+2 cycles.
  - `psel` dropping before completion: return to IDLE with no side effects.
- Outputs during a transfer:
  - `prdata` and `pslverr` are driven only in the `pready` cycle; otherwise `prdata`=0 and `pslverr`=0.
  - Error reads return `prdata`=0.
- Commit rule: register updates, FIFO pops and overflow clears take effect at the rising edge where `psel`&`penable`&`pready`=1.
- Mailbox FIFO (circular buffer, wrap-around pointers):
  - Push when not full stores `mbox_data_i` at the tail.
  - Push when full with no simultaneous pop: data is dropped and overflow is set.
  - Simultaneous push and pop:
    - Both are performed and count is unchanged.
    - When full, the push is accepted.
    - When empty, the pop is an error (`pslverr`=1, `prdata`=0) and the push still succeeds.
  - Read of MBOX_DATA when empty: `pslverr`=1, `prdata`=0, pointers unchanged.
  - `mbox_full_o` = (count==FIFO_DEPTH), from registered count.
- `irq_o` is a registered output, asserted one cycle after the condition becomes true.

Optional Feature:
- Macro: MBOX_IRQ_EN.
- Defined: the IRQ_EN register exists at 0x10C. `irq_o` = IRQ_EN[0] & (!empty | overflow), registered.
- Undefined: 0x10C decodes as error, `irq_o` is tied to 0, and no IRQ_EN storage exists.

Test Plan:
- Write 0xDEADBEEF to 0x008 with WAIT_CYCLES=1, then read it back → `pready` high on 3rd cycle of each transfer; `regs_o[95:64]`=0xDEADBEEF; read returns 0xDEADBEEF; `pslverr`=0.
- Push 0x11, 0x22, 0x33, 0x44 via `mbox_push_i` (FIFO_DEPTH=4), then push 0x55 → `mbox_full_o`=1; MBOX_STAT reads 0x000000C4. Four reads of 0x104 return 0x11, 0x22, 0x33, 0x44; a fifth read gives `pslverr`=1, `prdata`=0.
- Write 0x80 to 0x108 after the overflow → MBOX_STAT bit 7 = 0; count unchanged.
- FIFO full, hardware push of 0x99 in the same edge as an APB pop of 0x104 → count stays 4, overflow is not set, last entry read is 0x99.
- Read 0x200 and write 0x100 → both `pslverr`=1; STATUS content unchanged; `regs_o` unchanged.
- Assert `rst_i` while in WAIT during a write to 0x000 → `regs_o`=0, `pready`=0. The next transfer completes normally. With MBOX_IRQ_EN defined, write IRQ_EN=1 and push one entry → `irq_o`=1 one cycle later; it goes 0 after the pop.
